// File: rtl/dcache_flush_sequencer_pkg.sv
// Shared types and defaults for the D$ flush sequencer and its way picker.
package dcache_flush_sequencer_pkg;

    localparam int DCACHE_NUM_SETS   = 64;
    localparam int DCACHE_NUM_WAYS   = 2;
    localparam int DCACHE_LINE_BYTES = 64;
    // Way field is sized for the largest supported associativity; the top narrows it.
    localparam int DCACHE_WAY_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_ISSUE,
        S_INVAL,
        S_DONE
    } flush_state_t;

    typedef struct packed {
        logic [31:0]             addr;
        logic [DCACHE_WAY_W-1:0] way;
    } wb_req_t;

    function automatic int way_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_way_picker.sv
// Combinational lowest-index picker over a per-way pending mask.
module dcache_way_picker
    import dcache_flush_sequencer_pkg::*;
#(
    parameter int NUM_WAYS = DCACHE_NUM_WAYS,
    parameter int IDX_BITS = way_idx_bits(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] mask_i,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                any_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_BITS'(i);
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/dcache_flush_sequencer.sv
// Full D$ flush: per set read tags/dirty, write back dirty lines, invalidate the set.
// Optional writeback counter output enabled by DCACHE_FLUSH_STATS_EN.
module dcache_flush_sequencer
    import dcache_flush_sequencer_pkg::*;
#(
    parameter  int NUM_SETS   = DCACHE_NUM_SETS,
    parameter  int NUM_WAYS   = DCACHE_NUM_WAYS,
    parameter  int LINE_BYTES = DCACHE_LINE_BYTES,
    localparam int SET_BITS   = $clog2(NUM_SETS),
    localparam int OFF_BITS   = $clog2(LINE_BYTES),
    localparam int TAG_BITS   = 32 - SET_BITS - OFF_BITS,
    localparam int WAY_BITS   = way_idx_bits(NUM_WAYS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_req,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic [SET_BITS-1:0]          evict_set,
    input  logic [NUM_WAYS*TAG_BITS-1:0] wb_tags,
    input  logic [NUM_WAYS-1:0]          line_valid,
    input  logic [NUM_WAYS-1:0]          line_dirty,
    output logic                         wb_req_valid,
    input  logic                         wb_req_ready,
    output logic [31:0]                  wb_req_addr,
    output logic [WAY_BITS-1:0]          wb_req_way,
    output logic                         inval_en,
    output logic [SET_BITS-1:0]          inval_set
`ifdef DCACHE_FLUSH_STATS_EN
    ,
    output logic [15:0]                  flush_wb_count
`endif
);

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

    flush_state_t                  state_q, state_d;
    logic [SET_BITS-1:0]           set_q, set_d;
    logic [NUM_WAYS-1:0]           pending_q, pending_d;
    logic [NUM_WAYS*TAG_BITS-1:0]  tags_q, tags_d;
    wb_req_t                       req_q, req_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          valid_q, valid_d;
    logic                          inval_q, inval_d;

    logic [WAY_BITS-1:0]           pick_idx;
    logic                          pick_any;
    logic                          handshake;
    logic [NUM_WAYS-1:0]           hs_clear;
    logic                          way_unused;

    assign handshake  = valid_q & wb_req_ready;
    assign hs_clear   = NUM_WAYS'(1) << req_q.way[WAY_BITS-1:0];
    assign way_unused = ^req_q.way;

    // Pending-mask and tag capture; the picker then looks at the next-cycle mask.
    always_comb begin
        pending_d = pending_q;
        tags_d    = tags_q;
        if (state_q == S_LATCH) begin
            pending_d = line_valid & line_dirty;
            tags_d    = wb_tags;
        end else if (state_q == S_ISSUE && handshake) begin
            pending_d = pending_q & ~hs_clear;
        end
    end

    dcache_way_picker #(
        .NUM_WAYS (NUM_WAYS),
        .IDX_BITS (WAY_BITS)
    ) u_way_picker (
        .mask_i (pending_d),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_READ;
                    set_d   = '0;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: state_d = pick_any ? S_ISSUE : S_INVAL;
            S_ISSUE: begin
                if (!pick_any) begin
                    state_d = S_INVAL;
                end
            end
            S_INVAL: begin
                if (set_q == LAST_SET) begin
                    state_d = S_DONE;
                end else begin
                    set_d   = set_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        valid_d = (state_d == S_ISSUE);
        inval_d = (state_d == S_INVAL);
        req_d   = req_q;
        if (state_d == S_ISSUE) begin
            req_d.addr = {tags_d[int'(pick_idx)*TAG_BITS +: TAG_BITS], set_q, {OFF_BITS{1'b0}}};
            req_d.way  = DCACHE_WAY_W'(pick_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            set_q     <= '0;
            pending_q <= '0;
            tags_q    <= '0;
            req_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            inval_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            pending_q <= pending_d;
            tags_q    <= tags_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            inval_q   <= inval_d;
        end
    end

    assign flush_busy   = busy_q;
    assign flush_done   = done_q;
    assign evict_set    = set_q;
    assign inval_set    = set_q;
    assign wb_req_valid = valid_q;
    assign wb_req_addr  = req_q.addr;
    assign wb_req_way   = req_q.way[WAY_BITS-1:0];
    assign inval_en     = inval_q;

`ifdef DCACHE_FLUSH_STATS_EN
    logic [15:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        wb_cnt_d = wb_cnt_q;
        if (state_q == S_IDLE && flush_req) begin
            wb_cnt_d = '0;
        end else if (handshake && wb_cnt_q != 16'hFFFF) begin
            wb_cnt_d = wb_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign flush_wb_count = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Scoreboard bench for dcache_flush_sequencer with a 1-cycle tag/dirty RAM model.
`timescale 1ns/1ps
module tb_dcache_flush_sequencer;

    localparam int NS = 64;
    localparam int NW = 2;
    localparam int TW = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush_req = 1'b0;
    logic           flush_busy, flush_done;
    logic [5:0]     evict_set, inval_set;
    logic [NW*TW-1:0] wb_tags = '0;
    logic [NW-1:0]  line_valid = '0;
    logic [NW-1:0]  line_dirty = '0;
    logic           wb_req_valid;
    logic           wb_req_ready = 1'b1;
    logic [31:0]    wb_req_addr;
    logic [0:0]     wb_req_way;
    logic           inval_en;
`ifdef DCACHE_FLUSH_STATS_EN
    logic [15:0]    flush_wb_count;
`endif

    dcache_flush_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .evict_set    (evict_set),
        .wb_tags      (wb_tags),
        .line_valid   (line_valid),
        .line_dirty   (line_dirty),
        .wb_req_valid (wb_req_valid),
        .wb_req_ready (wb_req_ready),
        .wb_req_addr  (wb_req_addr),
        .wb_req_way   (wb_req_way),
        .inval_en     (inval_en),
        .inval_set    (inval_set)
`ifdef DCACHE_FLUSH_STATS_EN
        ,
        .flush_wb_count (flush_wb_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 writeback, 1 invalidate, 2 done
        logic [31:0] addr;
        int          val;    // way / set / latency
        bit          b2b;
    } ev_t;

    typedef struct {
        int          set;
        logic [31:0] addr;
        int          way;
        bit          b2b;
    } wb_exp_t;

    ev_t     sb[$];
    wb_exp_t wbt[$];

    logic [TW-1:0] m_tag   [NS][NW];
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_hs = 0;
    int stall_set = -1;
    int stall_len = 0;
    int stall_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic [0:0]  prev_way = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Tag/dirty read port: data for evict_set appears one cycle later.
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            wb_tags[w*TW +: TW] <= m_tag[evict_set][w];
            line_valid[w]       <= m_valid[evict_set][w];
            line_dirty[w]       <= m_dirty[evict_set][w];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: kind %0d seen, scoreboard empty (t=%0t)", kind, $time);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        if (e.kind == kind) begin
            case (kind)
                0: begin
                    chk("wb_addr", wb_req_addr, e.addr);
                    chk("wb_way", 32'(wb_req_way), e.val);
                    if (e.b2b) chk("wb_back_to_back", cyc - last_hs, 1);
                    $display("WB   addr=%08h way=%0d cyc=%0d", wb_req_addr, wb_req_way, cyc);
                end
                1: chk("inval_set", 32'(inval_set), e.val);
                default: begin
                    chk("done_latency", cyc - acc_cyc, e.val);
                    $display("DONE latency=%0d", cyc - acc_cyc);
                end
            endcase
        end
        if (kind == 0) last_hs = cyc;
    endtask

    // Ready generator first, then the monitor sees the ready the next edge will use.
    always @(negedge clk) begin
        if (rst) begin
            wb_req_ready = 1'b1;
            prev_stall   = 1'b0;
        end else begin
            if (wb_req_valid && int'(evict_set) == stall_set && stall_cnt < stall_len) begin
                wb_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                wb_req_ready = 1'b1;
            end
            if (prev_stall) begin
                chk("stall_valid_held", wb_req_valid, 1);
                chk("stall_addr_held", wb_req_addr, prev_addr);
                chk("stall_way_held", 32'(wb_req_way), 32'(prev_way));
            end
            prev_stall = wb_req_valid && !wb_req_ready;
            prev_addr  = wb_req_addr;
            prev_way   = wb_req_way;
            if (flush_req && !flush_busy) acc_cyc = cyc;
            if (wb_req_valid && wb_req_ready) take(0);
            if (inval_en) take(1);
            if (flush_done) take(2);
        end
    end

    task automatic expect_flush(input int lat);
        ev_t e;
        for (int s = 0; s < NS; s++) begin
            foreach (wbt[i]) begin
                if (wbt[i].set == s) begin
                    e = '{0, wbt[i].addr, wbt[i].way, wbt[i].b2b};
                    sb.push_back(e);
                end
            end
            e = '{1, 32'h0, s, 1'b0};
            sb.push_back(e);
        end
        e = '{2, 32'h0, lat, 1'b0};
        sb.push_back(e);
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, flush_busy, 0);
        chk({tag, "_done"}, flush_done, 0);
        chk({tag, "_wb_valid"}, wb_req_valid, 0);
        chk({tag, "_inval_en"}, inval_en, 0);
        chk({tag, "_evict_set"}, 32'(evict_set), 0);
        chk({tag, "_wb_addr"}, wb_req_addr, 0);
        chk({tag, "_wb_way"}, 32'(wb_req_way), 0);
        chk({tag, "_inval_set"}, 32'(inval_set), 0);
`ifdef DCACHE_FLUSH_STATS_EN
        chk({tag, "_wb_count"}, 32'(flush_wb_count), 0);
`endif
    endtask

    task automatic start_flush();
        @(posedge clk);
        #2 flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
        chk("busy_after_accept", flush_busy, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (flush_done !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, flush_done, 1);
        @(posedge clk);
        #1;
        chk({name, "_busy_cleared"}, flush_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst = 1'b0;

        // Clean cache: 64 invalidates, done 3*64+1 cycles after acceptance.
        wbt.delete();
        expect_flush(193);
        start_flush();
        repeat (40) @(posedge clk);
        #2 flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
        wait_done("clean");

        // Mixed: set5 way1, set63 both ways with a 10-cycle stall, set7 dirty-but-invalid.
        m_tag[5][0] = 20'h55555; m_valid[5][0] = 1'b1;
        m_tag[5][1] = 20'hABCDE; m_valid[5][1] = 1'b1; m_dirty[5][1] = 1'b1;
        m_tag[7][0] = 20'h11111; m_dirty[7][0] = 1'b1;
        m_tag[7][1] = 20'h22222; m_valid[7][1] = 1'b1;
        m_tag[63][0] = 20'h12345; m_valid[63][0] = 1'b1; m_dirty[63][0] = 1'b1;
        m_tag[63][1] = 20'h0FEDC; m_valid[63][1] = 1'b1; m_dirty[63][1] = 1'b1;
        wbt.delete();
        wbt.push_back('{5, 32'hABCDE140, 1, 1'b0});
        wbt.push_back('{63, 32'h12345FC0, 0, 1'b0});
        wbt.push_back('{63, 32'h0FEDCFC0, 1, 1'b1});
        expect_flush(193 + 3 + 10);
        stall_set = 63; stall_len = 10; stall_cnt = 0;
        start_flush();
        wait_done("mixed");
        chk("stall_cycles_used", stall_cnt, 10);
`ifdef DCACHE_FLUSH_STATS_EN
        chk("stats_count_after_mixed", 32'(flush_wb_count), 3);
`endif
        clear_model();

        // Abort with reset while stalled in ISSUE at set 12.
        m_tag[12][0] = 20'h0AAAA; m_valid[12][0] = 1'b1; m_dirty[12][0] = 1'b1;
        m_tag[12][1] = 20'h0BBBB; m_valid[12][1] = 1'b1; m_dirty[12][1] = 1'b1;
        wbt.delete();
        wbt.push_back('{12, 32'h0AAAA300, 0, 1'b0});
        wbt.push_back('{12, 32'h0BBBB300, 1, 1'b1});
        expect_flush(0);
        stall_set = 12; stall_len = 1000000; stall_cnt = 0;
        start_flush();
`ifdef DCACHE_FLUSH_STATS_EN
        chk("stats_cleared_on_accept", 32'(flush_wb_count), 0);
`endif
        n = 0;
        while (!(wb_req_valid === 1'b1 && evict_set == 6'd12) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_issue_set12", 32'(wb_req_valid && evict_set == 6'd12), 1);
        chk("issue_addr_set12", wb_req_addr, 32'h0AAAA300);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        $display("RST  asserted mid-flush at cyc=%0d", cyc);
        sb.delete();
        stall_len = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("idle_after_release", flush_busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("quiet_after_release", 32'(wb_req_valid | inval_en | flush_done), 0);

        // Fresh flush after the abort must restart from set 0.
        expect_flush(193 + 2);
        start_flush();
        wait_done("post_reset");
`ifdef DCACHE_FLUSH_STATS_EN
        chk("stats_count_post_reset", 32'(flush_wb_count), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
